// File: rtl/alu_flag_stage_if.sv
// Valid/ready result channel carrying a logic-unit word plus its Z and CF flags.
// The producer side uses the master modport, the consumer side the slave modport.
interface alu_flag_stage_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data;
  logic             z;
  logic             cf;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output z,
    output cf,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  z,
    input  cf,
    input  valid,
    output ready
  );
endinterface

// File: rtl/alu_flag_stage.sv
// Registered flag/result stage behind the 4-bit logic unit: small FIFO, sticky flags, result counter.
// Optional macro FLAG_STAGE_PARITY_EN adds per-entry even parity and the out_perr_o output.
module alu_flag_stage #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_flag_stage_if.slave  in_if,
  alu_flag_stage_if.master out_if,
  input  logic             clr_i,
  output logic             sticky_z_o,
  output logic             sticky_cf_o,
  output logic             flag_err_o,
  output logic [CNT_W-1:0] result_cnt_o
`ifdef FLAG_STAGE_PARITY_EN
  ,
  output logic             out_perr_o
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int DW = WIDTH + 2;
`ifdef FLAG_STAGE_PARITY_EN
  localparam int EW = DW + 1;
`else
  localparam int EW = DW;
`endif

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rdy_en_q;
  logic [DW-1:0]    last_q, last_d;
  logic             sticky_z_q, sticky_z_d;
  logic             sticky_cf_q, sticky_cf_d;
  logic             flag_err_q, flag_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_ready;
  logic             not_empty;
  logic             push;
  logic             pop;
  logic             in_mismatch;
  logic [DW-1:0]    in_word;
  logic [EW-1:0]    in_entry;
  logic [EW-1:0]    head_entry;
  logic [DW-1:0]    head_word;

  // rdy_en_q keeps the input side closed until the first edge after reset release
  assign in_ready    = rdy_en_q && (count_q != CW'(DEPTH));
  assign not_empty   = (count_q != '0);
  assign push        = in_if.valid && in_ready;
  assign pop         = not_empty && out_if.ready;
  assign in_word     = {in_if.cf, in_if.z, in_if.data};
  assign in_mismatch = (in_if.z != (in_if.data == '0));
  assign head_entry  = mem_q[rd_ptr_q];

`ifdef FLAG_STAGE_PARITY_EN
  assign in_entry = {^in_word, in_word};
`else
  assign in_entry = in_word;
`endif

  // When empty the outputs show the word most recently handed to the consumer
  assign head_word = not_empty ? head_entry[DW-1:0] : last_q;

  assign in_if.ready   = in_ready;
  assign out_if.valid  = not_empty;
  assign out_if.data   = head_word[WIDTH-1:0];
  assign out_if.z      = head_word[WIDTH];
  assign out_if.cf     = head_word[WIDTH+1];

  assign sticky_z_o    = sticky_z_q;
  assign sticky_cf_o   = sticky_cf_q;
  assign flag_err_o    = flag_err_q;
  assign result_cnt_o  = cnt_q;

`ifdef FLAG_STAGE_PARITY_EN
  assign out_perr_o = not_empty && (head_entry[DW] != ^head_entry[DW-1:0]);
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      last_d   = head_entry[DW-1:0];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A push in the same cycle as clr_i restarts the sticky bits from that push
  always_comb begin
    sticky_z_d  = clr_i ? 1'b0 : sticky_z_q;
    sticky_cf_d = clr_i ? 1'b0 : sticky_cf_q;
    flag_err_d  = clr_i ? 1'b0 : flag_err_q;
    cnt_d       = clr_i ? '0   : cnt_q;
    if (push) begin
      sticky_z_d  = sticky_z_d  | in_if.z;
      sticky_cf_d = sticky_cf_d | in_if.cf;
      flag_err_d  = flag_err_d  | in_mismatch;
      cnt_d       = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rdy_en_q    <= 1'b0;
      last_q      <= '0;
      sticky_z_q  <= 1'b0;
      sticky_cf_q <= 1'b0;
      flag_err_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rdy_en_q    <= 1'b1;
      last_q      <= last_d;
      sticky_z_q  <= sticky_z_d;
      sticky_cf_q <= sticky_cf_d;
      flag_err_q  <= flag_err_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Self-checking bench for alu_flag_stage: directed scenarios plus a randomized run against a queue model.
module tb_alu_flag_stage;
  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             sticky_z, sticky_cf, flag_err;
  logic [CNT_W-1:0] result_cnt;
`ifdef FLAG_STAGE_PARITY_EN
  logic             out_perr;
`endif

  int n_cmp;
  int n_err;

  alu_flag_stage_if #(.WIDTH(WIDTH)) up_if ();
  alu_flag_stage_if #(.WIDTH(WIDTH)) dn_if ();

  alu_flag_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_if        (up_if),
    .out_if       (dn_if),
    .clr_i        (clr),
    .sticky_z_o   (sticky_z),
    .sticky_cf_o  (sticky_cf),
    .flag_err_o   (flag_err),
    .result_cnt_o (result_cnt)
`ifdef FLAG_STAGE_PARITY_EN
    ,
    .out_perr_o   (out_perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic z, input logic cf);
    up_if.valid = v;
    up_if.data  = d;
    up_if.z     = z;
    up_if.cf    = cf;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    dn_if.ready = 1'b0;
    clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", dn_if.valid); end
    n_cmp++; if (dn_if.data !== 4'h0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", dn_if.data); end
    n_cmp++; if ({dn_if.z, dn_if.cf} !== 2'b00) begin n_err++; $display("FAIL rst_out_flags: got %b want 00", {dn_if.z, dn_if.cf}); end
    n_cmp++; if (up_if.ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", up_if.ready); end
    n_cmp++; if ({sticky_z, sticky_cf, flag_err} !== 3'b000) begin n_err++; $display("FAIL rst_sticky: got %b want 000", {sticky_z, sticky_cf, flag_err}); end
    n_cmp++; if (result_cnt !== 8'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", result_cnt); end
    tick();
    n_cmp++; if (up_if.ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_clocked: got %b want 0", up_if.ready); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (up_if.ready !== 1'b0) begin n_err++; $display("FAIL rel_ready_before_edge: got %b want 0", up_if.ready); end
    tick();
    n_cmp++; if (up_if.ready !== 1'b1) begin n_err++; $display("FAIL rel_ready_after_edge: got %b want 1", up_if.ready); end
  endtask

  task automatic test_basic();
    dn_if.ready = 1'b1;
    drive(1'b1, 4'b1111, 1'b0, 1'b0);
    tick();
    n_cmp++; if (dn_if.valid !== 1'b1) begin n_err++; $display("FAIL basic_valid1: got %b want 1", dn_if.valid); end
    n_cmp++; if ({dn_if.cf, dn_if.z, dn_if.data} !== 6'b00_1111) begin n_err++; $display("FAIL basic_head1: got %b want 001111", {dn_if.cf, dn_if.z, dn_if.data}); end
    drive(1'b1, 4'b0000, 1'b1, 1'b0);
    tick();
    n_cmp++; if (dn_if.valid !== 1'b1) begin n_err++; $display("FAIL basic_valid2: got %b want 1", dn_if.valid); end
    n_cmp++; if ({dn_if.cf, dn_if.z, dn_if.data} !== 6'b01_0000) begin n_err++; $display("FAIL basic_head2: got %b want 010000", {dn_if.cf, dn_if.z, dn_if.data}); end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL basic_drained: got %b want 0", dn_if.valid); end
    n_cmp++; if ({dn_if.cf, dn_if.z, dn_if.data} !== 6'b01_0000) begin n_err++; $display("FAIL basic_hold_last: got %b want 010000", {dn_if.cf, dn_if.z, dn_if.data}); end
    n_cmp++; if ({sticky_z, sticky_cf, flag_err} !== 3'b100) begin n_err++; $display("FAIL basic_sticky: got %b want 100", {sticky_z, sticky_cf, flag_err}); end
    n_cmp++; if (result_cnt !== 8'd2) begin n_err++; $display("FAIL basic_cnt: got %0d want 2", result_cnt); end
  endtask

  task automatic test_back_to_back();
    dn_if.ready = 1'b0;
    drive(1'b1, 4'b1110, 1'b0, 1'b0);
    tick();
    n_cmp++; if (up_if.ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after1: got %b want 1", up_if.ready); end
    drive(1'b1, 4'b1100, 1'b0, 1'b0);
    tick();
    n_cmp++; if (up_if.ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_full: got %b want 0", up_if.ready); end
    drive(1'b1, 4'b0110, 1'b0, 1'b0);
    tick();
    n_cmp++; if (dn_if.data !== 4'b1110) begin n_err++; $display("FAIL b2b_head_stall: got %b want 1110", dn_if.data); end
    n_cmp++; if (result_cnt !== 8'd4) begin n_err++; $display("FAIL b2b_third_held: got cnt %0d want 4", result_cnt); end
    tick();
    n_cmp++; if (dn_if.data !== 4'b1110) begin n_err++; $display("FAIL b2b_head_stable: got %b want 1110", dn_if.data); end
    // full: pop and push request together -> pop only
    dn_if.ready = 1'b1;
    tick();
    n_cmp++; if (dn_if.data !== 4'b1100) begin n_err++; $display("FAIL full_pop_head: got %b want 1100", dn_if.data); end
    n_cmp++; if (result_cnt !== 8'd4) begin n_err++; $display("FAIL full_no_push: got cnt %0d want 4", result_cnt); end
    n_cmp++; if (up_if.ready !== 1'b1) begin n_err++; $display("FAIL full_ready_back: got %b want 1", up_if.ready); end
    dn_if.ready = 1'b0;
    tick();
    n_cmp++; if (result_cnt !== 8'd5) begin n_err++; $display("FAIL full_next_push: got cnt %0d want 5", result_cnt); end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    dn_if.ready = 1'b1;
    tick();
    n_cmp++; if ({dn_if.valid, dn_if.data} !== 5'b1_0110) begin n_err++; $display("FAIL full_drain_order: got %b want 10110", {dn_if.valid, dn_if.data}); end
    tick();
    n_cmp++; if ({dn_if.valid, dn_if.data} !== 5'b0_0110) begin n_err++; $display("FAIL full_drain_empty: got %b want 00110", {dn_if.valid, dn_if.data}); end
  endtask

  task automatic test_flag_err_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_cmp++; if ({sticky_z, sticky_cf, flag_err, result_cnt} !== 11'd0) begin n_err++; $display("FAIL clr_all: got %b want 0", {sticky_z, sticky_cf, flag_err, result_cnt}); end
    drive(1'b1, 4'b0000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    n_cmp++; if (flag_err !== 1'b1) begin n_err++; $display("FAIL ferr_set: got %b want 1", flag_err); end
    tick();
    tick();
    n_cmp++; if (flag_err !== 1'b1) begin n_err++; $display("FAIL ferr_sticky: got %b want 1", flag_err); end
    clr = 1'b1;
    drive(1'b1, 4'b1000, 1'b0, 1'b1);
    tick();
    clr = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    n_cmp++; if ({sticky_z, sticky_cf, flag_err} !== 3'b010) begin n_err++; $display("FAIL clr_push_sticky: got %b want 010", {sticky_z, sticky_cf, flag_err}); end
    n_cmp++; if (result_cnt !== 8'd1) begin n_err++; $display("FAIL clr_push_cnt: got %0d want 1", result_cnt); end
    n_cmp++; if ({dn_if.valid, dn_if.cf, dn_if.data} !== 6'b1_1_1000) begin n_err++; $display("FAIL clr_push_fifo: got %b want 111000", {dn_if.valid, dn_if.cf, dn_if.data}); end
    tick();
  endtask

  task automatic test_wrap_and_reset();
    logic [3:0] d;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    dn_if.ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      d = 4'($urandom);
      drive(1'b1, d, (d == 4'h0), 1'($urandom));
      tick();
    end
    n_cmp++; if (result_cnt !== 8'd255) begin n_err++; $display("FAIL wrap_255: got %0d want 255", result_cnt); end
    drive(1'b1, 4'b0101, 1'b0, 1'b1);
    tick();
    n_cmp++; if (result_cnt !== 8'd0) begin n_err++; $display("FAIL wrap_0: got %0d want 0", result_cnt); end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    dn_if.ready = 1'b0;
    tick();
    n_cmp++; if ({dn_if.valid, dn_if.data} !== 5'b1_0101) begin n_err++; $display("FAIL mid_queued: got %b want 10101", {dn_if.valid, dn_if.data}); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (dn_if.valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", dn_if.valid); end
    n_cmp++; if ({dn_if.cf, dn_if.z, dn_if.data} !== 6'd0) begin n_err++; $display("FAIL mid_rst_out: got %b want 0", {dn_if.cf, dn_if.z, dn_if.data}); end
    n_cmp++; if ({up_if.ready, sticky_z, sticky_cf, flag_err, result_cnt} !== 12'd0) begin n_err++; $display("FAIL mid_rst_state: got %b want 0", {up_if.ready, sticky_z, sticky_cf, flag_err, result_cnt}); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [5:0]       q[$];
    logic [5:0]       last;
    logic [5:0]       head;
    logic             m_sz, m_scf, m_fe;
    logic [CNT_W-1:0] m_cnt;
    logic             v, r, c, z, cf, do_push, do_pop;
    logic [3:0]       d;
    do_reset();
    last = '0; m_sz = 0; m_scf = 0; m_fe = 0; m_cnt = '0;
    for (int i = 0; i < 400; i++) begin
      head = (q.size() > 0) ? q[0] : last;
      n_cmp++; if (dn_if.valid !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, dn_if.valid, (q.size() > 0)); end
      n_cmp++; if ({dn_if.cf, dn_if.z, dn_if.data} !== head) begin n_err++; $display("FAIL rnd_head[%0d]: got %b want %b", i, {dn_if.cf, dn_if.z, dn_if.data}, head); end
      n_cmp++; if (up_if.ready !== (q.size() < DEPTH)) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, up_if.ready, (q.size() < DEPTH)); end
      n_cmp++; if ({sticky_z, sticky_cf, flag_err} !== {m_sz, m_scf, m_fe}) begin n_err++; $display("FAIL rnd_sticky[%0d]: got %b want %b", i, {sticky_z, sticky_cf, flag_err}, {m_sz, m_scf, m_fe}); end
      n_cmp++; if (result_cnt !== m_cnt) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, result_cnt, m_cnt); end
      v  = ($urandom_range(0, 9) < 7);
      r  = ($urandom_range(0, 9) < 5);
      c  = ($urandom_range(0, 19) == 0);
      d  = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
      z  = ($urandom_range(0, 14) == 0) ? (d != 4'h0) : (d == 4'h0);
      cf = 1'($urandom);
      drive(v, d, z, cf);
      dn_if.ready = r;
      clr = c;
      do_push = v && (q.size() < DEPTH);
      do_pop  = r && (q.size() > 0);
      if (do_pop) last = q.pop_front();
      if (c) begin m_sz = 0; m_scf = 0; m_fe = 0; m_cnt = '0; end
      if (do_push) begin
        q.push_back({cf, z, d});
        m_sz  = m_sz | z;
        m_scf = m_scf | cf;
        m_fe  = m_fe | (z != (d == 4'h0));
        m_cnt = m_cnt + 1'b1;
      end
      tick();
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    clr = 1'b0;
  endtask

`ifdef FLAG_STAGE_PARITY_EN
  task automatic test_parity();
    do_reset();
    drive(1'b1, 4'b1001, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    n_cmp++; if (out_perr !== 1'b0) begin n_err++; $display("FAIL par_clean: got %b want 0", out_perr); end
    dut.mem_q[dut.rd_ptr_q] = dut.mem_q[dut.rd_ptr_q] ^ 7'b000_0001;
    #1;
    n_cmp++; if (out_perr !== 1'b1) begin n_err++; $display("FAIL par_flip: got %b want 1", out_perr); end
    dn_if.ready = 1'b1;
    tick();
    n_cmp++; if (out_perr !== 1'b0) begin n_err++; $display("FAIL par_popped: got %b want 0", out_perr); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    dn_if.ready = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_back_to_back();
    test_flag_err_clr();
    test_wrap_and_reset();
    test_random();
`ifdef FLAG_STAGE_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_flag_stage.md
Name: alu_flag_stage

Overview:
- Registered output stage directly downstream of the 4-bit NOT/logic unit; captures its result word plus Z (zero) and CF (carry) flags.
- Buffers results in a small FIFO with valid/ready handshake toward the consumer (register-file write-back or display driver).
- Maintains sticky flags, a result counter and a flag-consistency error bit for debug.

Parameters:
WIDTH, 4, result word width (matches logic-unit OUT)
DEPTH, 2, FIFO entries; power of two, >= 2
CNT_W, 8, width of accepted-result counter

Ports:
CLK  input  1  single system clock, rising edge
RST_N  input  1  asynchronous active-low reset
IN_DATA  input  WIDTH  result word from logic unit
IN_Z  input  1  zero flag from logic unit
IN_CF  input  1  carry flag from logic unit
IN_VALID  input  1  upstream result valid
IN_READY  output  1  stage can accept a result
OUT_DATA  output  WIDTH  head-of-FIFO result word
OUT_Z  output  1  head-of-FIFO zero flag
OUT_CF  output  1  head-of-FIFO carry flag
OUT_VALID  output  1  FIFO non-empty
OUT_READY  input  1  consumer accepts head entry
STICKY_Z  output  1  any accepted result had Z=1 since last clear
STICKY_CF  output  1  any accepted result had CF=1 since last clear
FLAG_ERR  output  1  sticky: accepted IN_Z disagreed with (IN_DATA==0)
CLR  input  1  synchronous clear of sticky bits and counter
RESULT_CNT  output  CNT_W  number of accepted results, wraps

Behaviour:
- Reset (RST_N low, asynchronous): FIFO empty, pointers 0; OUT_VALID=0, OUT_DATA=0, OUT_Z=0, OUT_CF=0; IN_READY=0 while RST_N low, 1 from first clock after release; STICKY_Z=STICKY_CF=FLAG_ERR=0; RESULT_CNT=0.
- Push when IN_VALID && IN_READY; entry {IN_CF, IN_Z, IN_DATA} written at rising edge.
- Pop when OUT_VALID && OUT_READY; read pointer advances at rising edge.
- IN_READY = (count != DEPTH), derived from registered count only; no combinational path from OUT_READY to IN_READY.
- OUT_* driven from head entry (registered storage, no input-to-output bypass); latency from accepted push to OUT_VALID high = 1 cycle.
- OUT_DATA/OUT_Z/OUT_CF hold stable while OUT_VALID && !OUT_READY.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Full (count==DEPTH): IN_READY=0, push ignored even if a pop occurs the same cycle.
- Empty: OUT_VALID=0, pop ignored; OUT_* hold last popped value.
- Pointers are log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.
- Sticky bits set on accepted push only: STICKY_Z |= IN_Z, STICKY_CF |= IN_CF, FLAG_ERR |= (IN_Z != (IN_DATA==0)).
- RESULT_CNT increments by 1 per accepted push, wraps 2^CNT_W-1 -> 0.
- CLR high: sticky bits and RESULT_CNT cleared next edge; FIFO contents untouched. CLR and a same-cycle push: push wins (sticky bits take this push's values, RESULT_CNT=1).
- Reset asserted mid-transfer: all state dropped immediately; in-flight entries lost.

Optional Feature:
- Macro FLAG_STAGE_PARITY_EN.
- Defined: each FIFO entry stores an extra even-parity bit over {IN_CF, IN_Z, IN_DATA}; extra output OUT_PERR (1 bit) is high when OUT_VALID and stored parity mismatches recomputed head parity; reset 0.
- Not defined: no parity storage, no OUT_PERR port; all other behaviour identical.

Test Plan:
- Reset release, OUT_READY=1, push DATA=4'b1111 Z=0 CF=0 then 4'b0000 Z=1 CF=0 -> OUT_VALID one cycle after each push, outputs in order, STICKY_Z=1, RESULT_CNT=2, FLAG_ERR=0.
- OUT_READY=0, push 4'b1110, 4'b1100, 4'b0110 back-to-back -> IN_READY falls after 2nd accept, 3rd held off; head stays 4'b1110 until OUT_READY=1.
- Full FIFO, OUT_READY=1 and IN_VALID=1 same cycle -> one pop, no push; next cycle push accepted.
- Push DATA=4'b0000 Z=0 -> FLAG_ERR=1 and stays 1 until CLR; CLR with simultaneous push of DATA=4'b1000 CF=1 -> STICKY_CF=1, RESULT_CNT=1, FLAG_ERR=0.
- 256 accepted pushes from 0 -> RESULT_CNT wraps to 0; assert RST_N low mid-stream with 1 entry queued -> OUT_VALID=0 immediately, all outputs 0.
- With FLAG_STAGE_PARITY_EN, force-flip one stored bit of head entry 4'b1001 -> OUT_PERR=1 while that entry is head.
